des_decrypt_iter: RTL and testbench
===================================

DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have no parameters; bit vectors SHALL be numbered [1:N], with bit 1 as the MSB (DES numbering).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous reset, active low.
REQ-005 in_valid  input  1  din and key are valid.
REQ-006 in_ready  output  1  block can accept a new ciphertext.
REQ-007 din  input  64  ciphertext block [1:64].
REQ-008 key  input  64  DES key [1:64]; parity bits 8,16,...,64 are ignored.
REQ-009 out_valid  output  1  dout holds the plaintext.
REQ-010 out_ready  input  1  consumer accepts dout.
REQ-011 dout  output  64  plaintext block [1:64].
REQ-012 busy  output  1  high while rounds are executing.

Function
REQ-013 The block SHALL perform iterative DES decryption, one Feistel round per clock, using a single instance of the existing des_f_structure round module (li, ri, ki -> lo, ro).
REQ-014 The FSM SHALL have three states: IDLE, ROUND, DONE. IDLE->ROUND on accept; ROUND->DONE after round 16; DONE->IDLE on out_valid&out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in ROUND.
REQ-016 Accept SHALL occur when in_valid&in_ready at a rising edge; on that edge the block SHALL register {L,R} <= IP(din), {C,D} <= PC-1(key), and round counter <= 1.
REQ-017 In ROUND, the subkey for round i SHALL be PC-2 of the working {C,D}. Before use, C and D SHALL each be rotated RIGHT by 0 for i=1, by 1 for i=2, 9 and 16, and by 2 otherwise. The rotated value SHALL be stored back into {C,D}.
REQ-018 This rotation schedule SHALL yield subkeys K16, K15, ..., K1 in rounds 1..16.
REQ-019 Each ROUND edge SHALL update {L,R} <= {lo,ro} and increment the counter.
REQ-020 On the round-16 edge, the block SHALL register dout <= FP({ro,lo}) (final swap, then inverse IP) and enter DONE.
REQ-021 Latency SHALL be exactly 16 cycles: with accept at edge N, out_valid rises after edge N+16.
REQ-022 dout and out_valid SHALL hold stable in DONE until out_ready is sampled high; the next accept is possible no earlier than the edge after the output handshake.
REQ-023 din and key changes while not in IDLE SHALL have no effect; the key is captured only at accept.
REQ-024 out_ready while not in DONE SHALL be ignored.
REQ-025 The round counter SHALL be 5 bits wide, with legal values 1..16; in ROUND, any other value SHALL force a return to IDLE without asserting out_valid.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set: state=IDLE, out_valid=0, busy=0, in_ready=1 (from the edge after reset), dout=64'h0, L=R=0, C=D=0, counter=0.
REQ-027 Reset asserted mid-operation (ROUND or DONE) SHALL abort the block with no output handshake; an accept SHALL be possible on the first edge with rst_n=1.
REQ-028 in_valid sampled during reset SHALL NOT be accepted.

Verification
REQ-029 Known-answer 1: key=133457799BBCDFF1, din=85E813540F0AB405 -> dout=0123456789ABCDEF, with out_valid exactly 16 cycles after accept.
REQ-030 Known-answer 2: key=0E329232EA6D0D73, din=0000000000000000 -> dout=8787878787878787.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> dout and out_valid stay stable, in_ready=0 throughout; release -> IDLE on the next edge, and a back-to-back second block decrypts correctly.
REQ-032 Mid-operation reset: assert rst_n=0 at round 8 for 1 cycle -> out_valid never rises for that block, dout=0; a new block decrypts correctly afterward.
REQ-033 Input churn: randomize din/key while busy -> result matches the captured inputs; in_valid held high while busy causes no extra accept.
REQ-034 Random test: 1000 random key/plaintext pairs, encrypted by a reference model and decrypted through the block -> dout equals the original plaintext, with parity bits of key randomized.

Source files
------------

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core. One Feistel round is evaluated per clock
// by a single shared round module. The key schedule is walked backwards by
// rotating C/D right, so that rounds 1..16 see subkeys K16..K1.
// All vectors use DES bit numbering: [1:N], with bit 1 as the MSB.

// One DES Feistel round: lo = ri, ro = li ^ f(ri, ki).
module des_f_structure (
  input  logic [1:32] li,
  input  logic [1:32] ri,
  input  logic [1:48] ki,
  output logic [1:32] lo,
  output logic [1:32] ro
);

  // Expansion E: 32 -> 48
  localparam int E_T [1:48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  // Permutation P applied to the S-box outputs
  localparam int P_T [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // S-boxes S1..S8. Each is 64 nibbles, row-major (4 rows x 16 columns);
  // the first table entry sits in the most significant nibble.
  localparam logic [1:8][255:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic [1:48] e_w;
  logic [1:48] x_w;
  logic [1:32] s_w;
  logic [1:32] p_w;

  for (genvar g = 1; g <= 48; g++) begin : g_expand
    assign e_w[g] = ri[E_T[g]];
  end

  assign x_w = e_w ^ ki;

  // Six-bit group: outer bits (1,6) pick the row, inner bits (2..5) the column.
  for (genvar g = 1; g <= 8; g++) begin : g_sbox
    logic [5:0] idx;
    assign idx = {x_w[6*g-5], x_w[6*g], x_w[6*g-4 : 6*g-1]};
    assign s_w[4*g-3 : 4*g] = 4'(SBOX[g] >> (9'd252 - {1'b0, idx, 2'b00}));
  end

  for (genvar g = 1; g <= 32; g++) begin : g_perm
    assign p_w[g] = s_w[P_T[g]];
  end

  assign lo = ri;
  assign ro = li ^ p_w;

endmodule

module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] din,
  input  logic [1:64] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] dout,
  output logic        busy
);

  // Initial permutation
  localparam int IP_T [1:64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  // Final permutation (inverse of IP)
  localparam int FP_T [1:64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // Permuted choice 1: drops the parity bits 8,16,...,64
  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: 56-bit {C,D} -> 48-bit subkey
  localparam int PC2_T [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:32] l_q;
  logic [1:32] r_q;
  logic [1:28] c_q;
  logic [1:28] d_q;
  logic [4:0]  cnt_q;
  logic [1:64] dout_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic [1:28] c_d;
  logic [1:28] d_d;
  logic [1:56] cd_d;
  logic [1:64] ip_w;
  logic [1:56] pc1_w;
  logic [1:48] k_w;
  logic [1:32] lo_w;
  logic [1:32] ro_w;
  logic [1:64] swap_w;
  logic [1:64] fp_w;
  logic        cnt_legal;
  logic        unused_parity;

  // Parity bits of the key play no part in the cipher.
  assign unused_parity = ^{key[8], key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};

  for (genvar g = 1; g <= 64; g++) begin : g_ip
    assign ip_w[g] = din[IP_T[g]];
  end

  for (genvar g = 1; g <= 56; g++) begin : g_pc1
    assign pc1_w[g] = key[PC1_T[g]];
  end

  // Walk the key schedule backwards: no rotation before round 1 (C16 == C0),
  // one step where encryption shifted by one, two steps elsewhere.
  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (cnt_q == 5'd2 || cnt_q == 5'd9 || cnt_q == 5'd16) begin
      c_d = {c_q[28], c_q[1:27]};
      d_d = {d_q[28], d_q[1:27]};
    end else if (cnt_q != 5'd1) begin
      c_d = {c_q[27:28], c_q[1:26]};
      d_d = {d_q[27:28], d_q[1:26]};
    end
  end

  assign cd_d = {c_d, d_d};

  for (genvar g = 1; g <= 48; g++) begin : g_pc2
    assign k_w[g] = cd_d[PC2_T[g]];
  end

  des_f_structure u_round (
    .li (l_q),
    .ri (r_q),
    .ki (k_w),
    .lo (lo_w),
    .ro (ro_w)
  );

  // The last round's halves are swapped back before the inverse IP.
  assign swap_w = {ro_w, lo_w};

  for (genvar g = 1; g <= 64; g++) begin : g_fp
    assign fp_w[g] = swap_w[FP_T[g]];
  end

  assign cnt_legal = (cnt_q >= 5'd1) && (cnt_q <= 5'd16);

  // Control FSM with registered handshake flags, plus the round datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            {l_q, r_q}  <= ip_w;
            {c_q, d_q}  <= pc1_w;
            cnt_q       <= 5'd1;
            state_q     <= ROUND;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ROUND: begin
          if (!cnt_legal) begin
            // A corrupted counter abandons the block without producing output.
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            l_q   <= lo_w;
            r_q   <= ro_w;
            c_q   <= c_d;
            d_q   <= d_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd16) begin
              dout_q      <= fp_w;
              state_q     <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: known answers, backpressure,
// input churn, mid-operation reset and a random sweep against an
// independent DES encryption model.
module tb_des_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] din;
  logic [1:64] key;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] dout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  des_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  // Reference tables (FIPS 46-3), 1-based source bit positions.
  int ip_q[$] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                  62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_q[$] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int pc1_q[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                   10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_q[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                   16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                   44,49,39,56,34,53, 46,42,50,36,29,32};
  int e_q[$] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                 28,29,30,31,32,1};
  int p_q[$] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  logic [255:0] sb_q[$] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic int tv(input int sel, input int i);
    case (sel)
      0:       return ip_q[i];
      1:       return fp_q[i];
      2:       return pc1_q[i];
      3:       return pc2_q[i];
      4:       return e_q[i];
      default: return p_q[i];
    endcase
  endfunction

  function automatic int tlen(input int sel);
    case (sel)
      0, 1:    return 64;
      2:       return 56;
      3, 4:    return 48;
      default: return 32;
    endcase
  endfunction

  // x is a right-aligned w-bit value; result is right-aligned.
  function automatic logic [63:0] perm(input logic [63:0] x, input int w, input int sel);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < tlen(sel); i++)
      o = (o << 1) | ((x >> (w - tv(sel, i))) & 64'd1);
    return o;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    int          idx;
    x = 48'(perm({32'd0, r}, 32, 4)) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b   = 6'(x >> (42 - 6 * j));
      idx = 16 * (2 * int'(b[5]) + int'(b[0])) + int'(b[4:1]);
      s   = {s[27:0], 4'(sb_q[j] >> (252 - 4 * idx))};
    end
    return 32'(perm({32'd0, s}, 32, 5));
  endfunction

  // Forward DES with the standard left-shift key schedule.
  function automatic logic [63:0] des_enc(input logic [63:0] k64, input logic [63:0] pt);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [31:0] l, r, nr;
    logic [47:0] ks;
    int          s;
    t = perm(k64, 64, 2);
    c = t[55:28];
    d = t[27:0];
    t = perm(pt, 64, 0);
    l = t[63:32];
    r = t[31:0];
    for (int i = 1; i <= 16; i++) begin
      s  = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      c  = (c << s) | (c >> (28 - s));
      d  = (d << s) | (d >> (28 - s));
      ks = 48'(perm({8'd0, c, d}, 56, 3));
      nr = l ^ f_fn(r, ks);
      l  = r;
      r  = nr;
    end
    return perm({r, l}, 64, 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ciphertext, wait for the plaintext, optionally stall the
  // consumer for 'hold' cycles, then complete the output handshake.
  // With churn set, din/key are scrambled, in_valid stays high and
  // out_ready is raised early while the rounds run.
  task automatic run_block(input string tag, input logic [63:0] k, input logic [63:0] c,
                           input logic [63:0] p, input int hold, input bit churn);
    int lat;
    key      = k;
    din      = c;
    in_valid = 1'b1;
    chk1({tag, "_in_ready_idle"}, in_ready, 1'b1);
    tick();
    in_valid = churn;
    if (churn) out_ready = 1'b1;
    chk1({tag, "_busy_after_accept"}, busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (churn) begin
        din = {$urandom, $urandom};
        key = {$urandom, $urandom};
      end
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd16);
    chk({tag, "_dout"}, dout, p);
    chk1({tag, "_in_ready_done"}, in_ready, 1'b0);
    chk1({tag, "_busy_done"}, busy, 1'b0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_dout"}, dout, p);
      chk1({tag, "_hold_out_valid"}, out_valid, 1'b1);
      chk1({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk1({tag, "_out_valid_after_hs"}, out_valid, 1'b0);
    chk1({tag, "_in_ready_after_hs"}, in_ready, 1'b1);
    chk1({tag, "_no_extra_accept"}, busy, 1'b0);
  endtask

  initial begin
    logic [63:0] rk, rp, rc;
    bit          seen;

    // Reset with a valid request pending: it must not be taken.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    key       = 64'h133457799BBCDFF1;
    din       = 64'h85E813540F0AB405;
    repeat (3) begin
      tick();
      chk1("rst_busy", busy, 1'b0);
    end
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", dout, 64'h0);

    // Sanity of the reference model against the known answers.
    chk("model_ka1", des_enc(64'h133457799BBCDFF1, 64'h0123456789ABCDEF), 64'h85E813540F0AB405);
    chk("model_ka2", des_enc(64'h0E329232EA6D0D73, 64'h8787878787878787), 64'h0000000000000000);

    // Accept on the very first edge with rst_n released.
    rst_n = 1'b1;
    run_block("ka1", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0);

    // Backpressure, then a back-to-back block right after the handshake.
    run_block("ka2_bp", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 10, 1'b0);
    run_block("b2b", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0);

    // Input churn and early out_ready while busy.
    run_block("churn", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 0, 1'b1);

    // Reset in the middle of round 8.
    key      = 64'h133457799BBCDFF1;
    din      = 64'h85E813540F0AB405;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk1("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_dout", dout, 64'h0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk1("abort_no_output", seen, 1'b0);
    run_block("after_abort", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 0, 1'b0);

    // Random sweep; parity bits of the key are random too.
    for (int n = 0; n < 1000; n++) begin
      rk = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      rc = des_enc(rk, rp);
      run_block("rand", rk, rc, rp, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
